// File: rtl/freq_synth_if.sv
// Memory-mapped register port of freq_synth: word address, zero-wait-state
// write and registered read data.
interface freq_synth_if;
  logic [2:0]  mm_address;
  logic        mm_write;
  logic [31:0] mm_writedata;
  logic        mm_read;
  logic [31:0] mm_readdata;

  modport master (
    output mm_address, mm_write, mm_writedata, mm_read,
    input  mm_readdata
  );

  modport slave (
    input  mm_address, mm_write, mm_writedata, mm_read,
    output mm_readdata
  );
endinterface

// File: rtl/freq_synth.sv
// freq_synth: NCO whose phase increment is FREQ*2^AccWidth/ReferenceClock, found by a serial divider.
// Optional TICKS counter at address 4 is built when FREQ_SYNTH_TICK_COUNT_EN is defined.
module freq_synth #(
  parameter int ReferenceClock = 50000000,
  parameter int AccWidth       = 32
) (
  input  logic        ref_clk,
  input  logic        reset_n,
  freq_synth_if.slave bus,
  output logic        tick,
  output logic        wave
);
  typedef enum logic [1:0] {IDLE, DIVIDE, APPLY} state_t;

  localparam logic [31:0]    REF_HZ   = 32'(ReferenceClock);
  localparam int             CntW     = $clog2(AccWidth + 1);
  localparam logic [CntW-1:0] CNT_LOAD = CntW'(AccWidth);

  state_t              r_state;
  logic [CntW-1:0]     r_cnt;
  logic [31:0]         r_rem;
  logic [AccWidth-1:0] r_quot;
  logic [AccWidth-1:0] r_incr;
  logic [AccWidth-1:0] r_acc;
  logic [31:0]         r_freq;
  logic                r_err;
  logic                r_en;
  logic                r_tick;
  logic [31:0]         r_readdata;

  logic                w_wr_freq;
  logic                w_freq_ok;
  logic                w_wr_status;
  logic                w_wr_ctrl;
  logic                w_busy;
  logic [32:0]         w_shift;
  logic                w_ge;
  logic [AccWidth:0]   w_sum;
  logic [31:0]         w_ticks;
  logic [31:0]         w_rdata;

  assign w_wr_freq   = bus.mm_write && (bus.mm_address == 3'd0);
  assign w_freq_ok   = bus.mm_writedata < REF_HZ;
  assign w_wr_status = bus.mm_write && (bus.mm_address == 3'd2);
  assign w_wr_ctrl   = bus.mm_write && (bus.mm_address == 3'd3);
  assign w_busy      = (r_state != IDLE);

  // Numerator low bits are all zero, so each restoring step shifts in a 0.
  assign w_shift = {r_rem, 1'b0};
  assign w_ge    = w_shift >= {1'b0, REF_HZ};
  assign w_sum   = {1'b0, r_acc} + {1'b0, r_incr};

  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quot  <= '0;
      r_incr  <= '0;
      r_freq  <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_wr_freq && !w_freq_ok)
        r_err <= 1'b1;
      else if (w_wr_status && bus.mm_writedata[1])
        r_err <= 1'b0;

      if (w_wr_freq && w_freq_ok) begin
        r_freq  <= bus.mm_writedata;
        r_rem   <= bus.mm_writedata;
        r_quot  <= '0;
        r_cnt   <= CNT_LOAD;
        r_state <= DIVIDE;
      end else begin
        case (r_state)
          DIVIDE: begin
            r_rem  <= w_ge ? 32'(w_shift - {1'b0, REF_HZ}) : w_shift[31:0];
            r_quot <= {r_quot[AccWidth-2:0], w_ge};
            r_cnt  <= r_cnt - 1'b1;
            if (r_cnt == CntW'(1))
              r_state <= APPLY;
          end
          APPLY: begin
            r_incr  <= r_quot;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en       <= 1'b0;
      r_readdata <= '0;
    end else begin
      if (w_wr_ctrl)
        r_en <= bus.mm_writedata[0];
      if (bus.mm_read)
        r_readdata <= w_rdata;
    end
  end

  // Phase is never cleared on an INCR change, only while disabled.
  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc  <= '0;
      r_tick <= 1'b0;
    end else if (r_en) begin
      r_acc  <= w_sum[AccWidth-1:0];
      r_tick <= w_sum[AccWidth];
    end else begin
      r_acc  <= '0;
      r_tick <= 1'b0;
    end
  end

`ifdef FREQ_SYNTH_TICK_COUNT_EN
  logic        w_wr_ticks;
  logic [31:0] r_ticks;

  assign w_wr_ticks = bus.mm_write && (bus.mm_address == 3'd4);

  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n)
      r_ticks <= '0;
    else if (w_wr_ticks)
      r_ticks <= '0;
    else if (r_tick)
      r_ticks <= r_ticks + 32'd1;
  end

  assign w_ticks = r_ticks;
`else
  assign w_ticks = '0;
`endif

  always_comb begin
    w_rdata = '0;
    case (bus.mm_address)
      3'd0:    w_rdata = r_freq;
      3'd1:    w_rdata = 32'(r_incr);
      3'd2:    w_rdata = {30'd0, r_err, w_busy};
      3'd3:    w_rdata = {31'd0, r_en};
      3'd4:    w_rdata = w_ticks;
      default: w_rdata = '0;
    endcase
  end

  assign bus.mm_readdata = r_readdata;
  assign tick            = r_tick;
  assign wave            = r_acc[AccWidth-1];
endmodule

// File: tb/tb_freq_synth.sv
// Randomized bench for freq_synth: register map, divider result and latency,
// and closed-form tick/wave prediction against the programmed increment.
module tb_freq_synth;
  localparam longint unsigned REF_HZ = 64'd50000000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic tick;
  logic wave;
  int   n_checks = 0;
  int   n_pass   = 0;

  freq_synth_if bus_if ();

  freq_synth dut (
    .ref_clk (clk),
    .reset_n (rst_n),
    .bus     (bus_if),
    .tick    (tick),
    .wave    (wave)
  );

  always #5 clk = ~clk;

  // Expected increment: floor(f * 2^32 / ReferenceClock).
  function automatic longint unsigned ref_incr(input longint unsigned f);
    return (f << 32) / REF_HZ;
  endfunction

  // All bus tasks start and end just after a falling edge.
  task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
    bus_if.mm_address   = addr;
    bus_if.mm_writedata = data;
    bus_if.mm_write     = 1'b1;
    @(negedge clk);
    bus_if.mm_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
    bus_if.mm_address = addr;
    bus_if.mm_read    = 1'b1;
    @(negedge clk);
    bus_if.mm_read    = 1'b0;
    data = bus_if.mm_readdata;
  endtask

  // Counts consecutive cycles STATUS.BUSY reads 1, starting right after a write.
  task automatic measure_busy(output int n);
    bus_if.mm_address = 3'd2;
    bus_if.mm_read    = 1'b1;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus_if.mm_readdata[0]) n++;
      else break;
    end
    bus_if.mm_read = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({tick, wave} !== 2'b00) $display("FAIL reset_outputs tick/wave=%b required 00", {tick, wave});
    else n_pass++;
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), d);
      n_checks++;
      if (d !== 32'd0) $display("FAIL reset_read addr=%0d got=%h required=0", a, d);
      else n_pass++;
    end
  endtask

  task automatic program_and_check(input logic [31:0] f);
    int n;
    logic [31:0] d;
    bus_write(3'd0, f);
    measure_busy(n);
    n_checks++;
    if (n !== 33) $display("FAIL busy_len freq=%0d got=%0d required=33", f, n);
    else n_pass++;
    bus_read(3'd1, d);
    n_checks++;
    if (d !== 32'(ref_incr(64'(f)))) $display("FAIL incr freq=%0d got=%0d required=%0d", f, d, ref_incr(64'(f)));
    else n_pass++;
    bus_read(3'd0, d);
    n_checks++;
    if (d !== f) $display("FAIL freq_readback got=%0d required=%0d", d, f);
    else n_pass++;
  endtask

  task automatic test_incr();
    logic [31:0] fixed_f [3] = '{32'd1, 32'd12500000, 32'd25000000};
    for (int i = 0; i < 3; i++) program_and_check(fixed_f[i]);
    for (int i = 0; i < 5; i++) program_and_check($urandom_range(49999999, 0));
  endtask

  task automatic test_tick_wave(input logic [31:0] f, input int cycles);
    longint unsigned inc;
    longint unsigned p;
    longint unsigned p_prev;
    logic exp_tick;
    logic exp_wave;
    bus_write(3'd3, 32'd0);
    program_and_check(f);
    inc = ref_incr(64'(f));
    n_checks++;
    if ({tick, wave} !== 2'b00) $display("FAIL disabled_idle freq=%0d tick/wave=%b required 00", f, {tick, wave});
    else n_pass++;
    bus_write(3'd3, 32'd1);
    for (int j = 1; j <= cycles; j++) begin
      @(negedge clk);
      p      = longint'(j) * inc;
      p_prev = longint'(j - 1) * inc;
      exp_tick = (p >> 32) != (p_prev >> 32);
      exp_wave = p[31];
      n_checks++;
      if (tick !== exp_tick || wave !== exp_wave)
        $display("FAIL tick_wave freq=%0d cycle=%0d got=%b%b required=%b%b", f, j, tick, wave, exp_tick, exp_wave);
      else n_pass++;
    end
    bus_write(3'd3, 32'd0);
    @(negedge clk);
    n_checks++;
    if ({tick, wave} !== 2'b00) $display("FAIL disable_outputs freq=%0d tick/wave=%b required 00", f, {tick, wave});
    else n_pass++;
  endtask

  task automatic test_err();
    logic [31:0] d;
    logic [31:0] prev_incr;
    logic [31:0] prev_freq;
    logic [31:0] bad;
    logic [31:0] f1;
    int n;
    bus_read(3'd1, prev_incr);
    bus_read(3'd0, prev_freq);
    for (int i = 0; i < 3; i++) begin
      bad = (i == 0) ? 32'd50000000 : 32'd50000000 + $urandom_range(32'hFFFFFFFF - 32'd50000000, 0);
      bus_write(3'd0, bad);
      bus_read(3'd2, d);
      n_checks++;
      if (d !== 32'h2) $display("FAIL err_set value=%0d status=%h required=2", bad, d);
      else n_pass++;
      bus_read(3'd1, d);
      n_checks++;
      if (d !== prev_incr) $display("FAIL err_incr_kept got=%0d required=%0d", d, prev_incr);
      else n_pass++;
      bus_read(3'd0, d);
      n_checks++;
      if (d !== prev_freq) $display("FAIL err_freq_kept got=%0d required=%0d", d, prev_freq);
      else n_pass++;
      bus_write(3'd2, 32'h2);
      bus_read(3'd2, d);
      n_checks++;
      if (d !== 32'h0) $display("FAIL err_clear status=%h required=0", d);
      else n_pass++;
    end
    // Invalid write four cycles into a division must not disturb it.
    f1 = $urandom_range(49999999, 1);
    bus_write(3'd0, f1);
    repeat (3) @(negedge clk);
    bus_write(3'd0, 32'hFFFFFFFF);
    measure_busy(n);
    n_checks++;
    if (n !== 29) $display("FAIL busy_after_invalid got=%0d required=29", n);
    else n_pass++;
    bus_read(3'd1, d);
    n_checks++;
    if (d !== 32'(ref_incr(64'(f1)))) $display("FAIL incr_after_invalid got=%0d required=%0d", d, ref_incr(64'(f1)));
    else n_pass++;
    bus_read(3'd2, d);
    n_checks++;
    if (d !== 32'h2) $display("FAIL err_while_busy status=%h required=2", d);
    else n_pass++;
    bus_write(3'd2, 32'h2);
  endtask

  task automatic test_restart();
    logic [31:0] d;
    int n;
    bus_write(3'd0, 32'd1000000);
    repeat (9) @(negedge clk);
    bus_write(3'd0, 32'd2000000);
    measure_busy(n);
    n_checks++;
    if (n !== 33) $display("FAIL restart_busy got=%0d required=33", n);
    else n_pass++;
    bus_read(3'd1, d);
    n_checks++;
    if (d !== 32'd171798691) $display("FAIL restart_incr got=%0d required=171798691", d);
    else n_pass++;
  endtask

  task automatic test_misc_regs();
    logic [31:0] d;
    // Read and write of CONTROL in the same cycle returns the old value.
    bus_if.mm_address   = 3'd3;
    bus_if.mm_writedata = 32'd1;
    bus_if.mm_write     = 1'b1;
    bus_if.mm_read      = 1'b1;
    @(negedge clk);
    bus_if.mm_write = 1'b0;
    bus_if.mm_read  = 1'b0;
    n_checks++;
    if (bus_if.mm_readdata !== 32'd0) $display("FAIL rw_same_cycle got=%h required=0", bus_if.mm_readdata);
    else n_pass++;
    bus_read(3'd3, d);
    n_checks++;
    if (d !== 32'd1) $display("FAIL ctrl_readback got=%h required=1", d);
    else n_pass++;
    bus_write(3'd3, 32'd0);
    for (int a = 5; a < 8; a++) begin
      bus_write(3'(a), $urandom());
      bus_read(3'(a), d);
      n_checks++;
      if (d !== 32'd0) $display("FAIL unused_addr addr=%0d got=%h required=0", a, d);
      else n_pass++;
    end
  endtask

  task automatic test_ticks();
    logic [31:0] d;
    bus_write(3'd3, 32'd0);
    program_and_check(32'd12500000);
`ifdef FREQ_SYNTH_TICK_COUNT_EN
    bus_write(3'd4, 32'd0);
    bus_read(3'd4, d);
    n_checks++;
    if (d !== 32'd0) $display("FAIL ticks_clear got=%0d required=0", d);
    else n_pass++;
    bus_write(3'd3, 32'd1);
    repeat (400) @(negedge clk);
    bus_write(3'd3, 32'd0);
    bus_read(3'd4, d);
    n_checks++;
    if (d !== 32'd99 && d !== 32'd100) $display("FAIL ticks_count got=%0d required=99..100", d);
    else n_pass++;
    bus_write(3'd4, 32'd0);
    bus_read(3'd4, d);
    n_checks++;
    if (d !== 32'd0) $display("FAIL ticks_reclear got=%0d required=0", d);
    else n_pass++;
`else
    bus_write(3'd3, 32'd1);
    repeat (40) @(negedge clk);
    bus_write(3'd3, 32'd0);
    bus_read(3'd4, d);
    n_checks++;
    if (d !== 32'd0) $display("FAIL ticks_absent got=%0d required=0", d);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_division();
    logic [31:0] d;
    bus_write(3'd0, 32'd25000000);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({tick, wave} !== 2'b00) $display("FAIL midreset_outputs tick/wave=%b required 00", {tick, wave});
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 3; a++) begin
      bus_read(3'(a), d);
      n_checks++;
      if (d !== 32'd0) $display("FAIL midreset_read addr=%0d got=%h required=0", a, d);
      else n_pass++;
    end
    repeat (40) @(negedge clk);
    bus_read(3'd1, d);
    n_checks++;
    if (d !== 32'd0) $display("FAIL midreset_no_apply got=%h required=0", d);
    else n_pass++;
  endtask

  initial begin
    bus_if.mm_address   = 3'd0;
    bus_if.mm_write     = 1'b0;
    bus_if.mm_writedata = 32'd0;
    bus_if.mm_read      = 1'b0;
    test_reset();
    test_incr();
    test_tick_wave(32'd12500000, 40);
    test_tick_wave(32'd25000000, 20);
    for (int i = 0; i < 3; i++) test_tick_wave($urandom_range(49999999, 1000000), 60);
    test_err();
    test_restart();
    test_misc_regs();
    test_ticks();
    test_reset_mid_division();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/freq_synth.md
# freq_synth

Programmable numerically-controlled oscillator on the reference clock. It is the generating counterpart of the frequency gauge. Software writes a target frequency in Hz over a memory-mapped port. The block converts it to a phase increment with a sequential divider and emits a single-cycle `tick` strobe plus a square `wave` at that frequency. It drives test clock-enables and self-checks the gauge path: synth output goes into the gauge probe, and the gauge reads back about FREQ.

## Interface
- `ReferenceClock`, 50000000 — `ref_clk` frequency in Hz.
- `AccWidth`, 32 — phase accumulator width; the divider runs for AccWidth cycles.
- `ref_clk`  in  1  — sole clock.
- `reset_n`  in  1  — reset; asynchronous, active-low.
- `mm_address`  in  3  — word address.
- `mm_write`  in  1  — write strobe, zero wait states.
- `mm_writedata`  in  32  — write data.
- `mm_read`  in  1  — read strobe.
- `mm_readdata`  out  32  — read data, registered.
- `tick`  out  1  — one-cycle strobe at the programmed frequency.
- `wave`  out  1  — accumulator MSB; roughly 50% duty square wave.

## Operation
- Register map:
  - 0 FREQ (RW): target Hz.
  - 1 INCR (RO): active increment.
  - 2 STATUS: bit0 BUSY (RO), bit1 ERR (W1C).
  - 3 CONTROL (RW): bit0 EN.
  - 4 TICKS (see Configuration).
  - 5–7: read 0, writes ignored.
- Reset state: all registers 0, accumulator 0, FSM IDLE, `tick`=0, `wave`=0, `mm_readdata`=0.
- FSM states are IDLE, DIVIDE and APPLY.
- IDLE → DIVIDE on a FREQ write with writedata < ReferenceClock.
  - FREQ is stored.
  - The divider loads numerator writedata·2^AccWidth, iteration counter = AccWidth.
- FREQ write with writedata ≥ ReferenceClock:
  - ERR is set.
  - FREQ, INCR and FSM are unchanged.
- DIVIDE performs one restoring-division step per cycle by the constant ReferenceClock, MSB first, producing one quotient bit per cycle.
- DIVIDE → APPLY after AccWidth steps.
- APPLY loads INCR = floor(FREQ·2^AccWidth / ReferenceClock), exact with no rounding, then returns to IDLE.
- A valid FREQ write in DIVIDE or APPLY restarts DIVIDE with the new value; the latest write wins and the old quotient is discarded.
- An invalid FREQ write while busy sets ERR and does not disturb the running division.
- The accumulator is not cleared on INCR change, so phase stays continuous.
- EN=1:
  - acc <= acc + INCR, mod 2^AccWidth, each cycle.
  - `tick` = registered carry-out of that add.
- EN=0:
  - Accumulator is held at 0, `tick`=0, `wave`=0.
  - Division still runs.
- INCR=0: no ticks, `wave` stays 0.
- Writing 1 to ERR clears it. If a set event coincides with a clear, the set wins.
- BUSY=1 in DIVIDE and APPLY.

## Timing
- FREQ write sampled at edge N:
  - BUSY reads 1 from cycle N+1.
  - New INCR is visible and used by the accumulator from edge N+AccWidth+1.
  - BUSY=0 from the same edge.
- Read: `mm_readdata` is valid the cycle after the `mm_read` edge and holds its value otherwise.
- Simultaneous read and write to the same register returns the old value.
- `tick`: one cycle high, registered.
  - Period is 2^AccWidth/INCR cycles on average, with jitter of 1 cycle.
- `wave` = acc[AccWidth-1], registered with the accumulator.
- EN 0→1 at edge M: first accumulate at M+1, so the earliest `tick` is at M+2.
- EN 1→0 at edge M: `tick` and `wave` are low from M+1.
- Reset assertion mid-division: immediate return to the reset state. No partial INCR is applied.

## Configuration
- `FREQ_SYNTH_TICK_COUNT_EN` defined:
  - Address 4 is TICKS, a 32-bit count of `tick` pulses that wraps at 2^32.
  - Any write to address 4 clears it. If a tick coincides with a clear, the result is 0.
- Undefined: address 4 reads 0 and no counter is built.

## Test plan
- Reset, then read all addresses → all 0; `tick`=0, `wave`=0.
- EN=1, FREQ=12500000 → BUSY high for 33 cycles, INCR=0x40000000; `tick` exactly every 4 cycles; `wave` period 4 cycles, 2 high.
- FREQ=1 → INCR=85; FREQ=25000000 → INCR=0x80000000, and `tick` every 2 cycles.
- FREQ=50000000 → ERR=1, INCR unchanged; write STATUS=0x2 → ERR=0.
- FREQ=1000000, then FREQ=2000000 ten cycles later → BUSY low exactly 33 cycles after the second write; INCR=171798691, never 85899345.
- With macro, FREQ=12500000 and EN=1 for 400 cycles → TICKS = 99 or 100; write address 4 → reads 0. Without macro → reads 0.
